// File: rtl/rr_merge_dataless.sv
// Round-robin merge of NUM_INPUTS dataless requesters onto one handshake channel.
// A single transparent buffer slot holds token+index while the consumer stalls.
module rr_merge_dataless #(
    parameter int NUM_INPUTS  = 4,
    parameter int INDEX_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_INPUTS-1:0]  ins_valid,
    output logic [NUM_INPUTS-1:0]  ins_ready,
    output logic                   outs_valid,
    input  logic                   outs_ready,
    output logic [INDEX_WIDTH-1:0] index
);

    localparam int RW = INDEX_WIDTH + 1;

    generate
        if ((1 << INDEX_WIDTH) < NUM_INPUTS) begin : g_width_check
            $error("rr_merge_dataless: INDEX_WIDTH too small for NUM_INPUTS");
        end
    endgenerate

    logic                   r_full;
    logic [INDEX_WIDTH-1:0] r_idx;
    logic [INDEX_WIDTH-1:0] r_ptr;

    logic                   w_any;
    logic                   w_acc;
    logic [INDEX_WIDTH-1:0] w_grant;
    logic [INDEX_WIDTH-1:0] w_ptr_next;
    logic [INDEX_WIDTH-1:0] w_rot_idx [NUM_INPUTS];
    logic [NUM_INPUTS-1:0]  w_rot_valid;

    // Offset gi from the pointer maps to input (ptr + gi) mod NUM_INPUTS.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_rot
            logic [RW-1:0] w_sum;
            logic [RW-1:0] w_wrapped;
            assign w_sum       = {1'b0, r_ptr} + RW'(gi);
            assign w_wrapped   = (w_sum >= RW'(NUM_INPUTS)) ? (w_sum - RW'(NUM_INPUTS)) : w_sum;
            assign w_rot_idx[gi]   = w_wrapped[INDEX_WIDTH-1:0];
            assign w_rot_valid[gi] = |(ins_valid & (NUM_INPUTS'(1) << w_rot_idx[gi]));
        end
    endgenerate

    assign w_any = |ins_valid;

    // Scan from the farthest offset down so the nearest valid offset wins.
    always_comb begin
        w_grant = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            if (w_rot_valid[k]) begin
                w_grant = w_rot_idx[k];
            end
        end
    end

    assign w_acc      = w_any & ~r_full;
    assign w_ptr_next = (w_grant == INDEX_WIDTH'(NUM_INPUTS - 1)) ? '0 : (w_grant + INDEX_WIDTH'(1));

    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_ready
            assign ins_ready[gi] = w_acc & (w_grant == INDEX_WIDTH'(gi));
        end
    endgenerate

    assign outs_valid = r_full | w_any;
    assign index      = r_full ? r_idx : w_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_idx  <= '0;
            r_ptr  <= '0;
        end else begin
            r_full <= (w_any | r_full) & ~outs_ready;
            if (w_acc & ~outs_ready) begin
                r_idx <= w_grant;
            end
            if (w_acc) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_rr_merge_dataless.sv
// Bench for rr_merge_dataless: directed vectors with literal expectations plus
// a per-cycle comparison against a behavioural round-robin/buffer model.
module tb_rr_merge_dataless;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  ins_valid;
    logic [N-1:0]  ins_ready;
    logic          outs_valid;
    logic          outs_ready;
    logic [IW-1:0] index;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    rr_merge_dataless #(.NUM_INPUTS(N), .INDEX_WIDTH(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready),
        .index      (index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: abstract buffer + pointer, grant found by modular scan from ptr.
    int m_full = 0;
    int m_idx  = 0;
    int m_ptr  = 0;
    int sb_q[$];
    int wait_cnt [N];

    function automatic int model_grant(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            int g;
            bit any, acc;
            logic [N-1:0] exp_rdy;
            any     = |ins_valid;
            g       = model_grant(ins_valid, m_ptr);
            acc     = any && (m_full == 0);
            exp_rdy = acc ? (N'(1) << g) : '0;
            chk("model_ins_ready", 32'(ins_ready), 32'(exp_rdy));
            chk("model_outs_valid", 32'(outs_valid), 32'(m_full != 0 || any));
            if (m_full != 0 || any)
                chk("model_index", 32'(index), 32'(m_full != 0 ? m_idx : g));
            if (acc) sb_q.push_back(g);
            if ((m_full != 0 || any) && outs_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_token_present", 32'(0), 32'(1));
                end else begin
                    int e;
                    e = sb_q.pop_front();
                    chk("sb_order_index", 32'(index), 32'(e));
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!ins_valid[i]) wait_cnt[i] = 0;
                else if (acc && g == i) begin
                    if (wait_cnt[i] > N) chk("fairness_wait", 32'(wait_cnt[i]), 32'(N));
                    wait_cnt[i] = 0;
                end else if (acc) wait_cnt[i]++;
            end
            if (rst) begin
                m_full = 0; m_idx = 0; m_ptr = 0;
                sb_q.delete();
                for (int i = 0; i < N; i++) wait_cnt[i] = 0;
            end else begin
                if (acc && !outs_ready) m_idx = g;
                if (acc) m_ptr = (g + 1) % N;
                m_full = ((any || m_full != 0) && !outs_ready) ? 1 : 0;
            end
        end
    end

    // One directed vector: drive, check literals mid-cycle, advance past the edge.
    task automatic vec(input string name, input logic [N-1:0] v, input logic r,
                       input logic [N-1:0] e_rdy, input logic e_ov, input logic [IW-1:0] e_idx);
        ins_valid  = v;
        outs_ready = r;
        @(negedge clk);
        chk({name, "_ready"}, 32'(ins_ready), 32'(e_rdy));
        chk({name, "_ovalid"}, 32'(outs_valid), 32'(e_ov));
        if (e_ov) chk({name, "_index"}, 32'(index), 32'(e_idx));
        $display("vec %-8s valid=%b ready=%b -> ins_ready=%b outs_valid=%b index=%0d",
                 name, v, r, ins_ready, outs_valid, index);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seq [6] = '{0, 1, 2, 3, 0, 1};
        logic [N-1:0] hs, nv;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        rst = 1'b1; ins_valid = '0; outs_ready = 1'b0;
        @(posedge clk); #1;
        started = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Full request set rotates 0,1,2,3,0,1.
        for (int c = 0; c < 6; c++)
            vec("rr_all", 4'b1111, 1'b1, N'(1) << seq[c], 1'b1, IW'(seq[c]));

        // Stall holds index 2; drain cycle accepts nothing; then re-accept.
        vec("stall0", 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2);
        vec("stall1", 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2);
        vec("stall2", 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2);
        vec("drain",  4'b0100, 1'b1, 4'b0000, 1'b1, 2'd2);
        vec("reacc",  4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2);

        // ptr=3: grants 3, wrap to 0, then 3.
        vec("wrap0", 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3);
        vec("wrap1", 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0);
        vec("wrap2", 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3);

        // Reset discards a buffered token and returns ptr to 0.
        vec("fill", 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1);
        rst = 1'b1;
        vec("rstcyc", 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1);
        rst = 1'b0;
        vec("postrst", 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0);
        vec("ptr0", 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1);

        // Idle cycles leave state untouched (ptr stays 2).
        for (int c = 0; c < 5; c++)
            vec("idle", 4'b0000, c[0], 4'b0000, 1'b0, 2'd0);
        vec("afteridl", 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2);

        // Random protocol-respecting traffic, checked by the model.
        ins_valid = '0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            hs = ins_valid & ins_ready;
            @(posedge clk); #1;
            nv = ins_valid;
            for (int i = 0; i < N; i++)
                if (!nv[i] || hs[i]) nv[i] = 1'($urandom_range(0, 1));
            ins_valid  = nv;
            outs_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        @(posedge clk); #1;
        ins_valid = '0; outs_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_merge_dataless.md
Name: rr_merge_dataless

Overview:
- Round-robin arbiter that shares one dataless handshake output channel between NUM_INPUTS dataless requesters.
- Each accepted token is forwarded with the index of the winning input.
- The output carries a single-slot transparent (zero-latency) buffer that holds token+index while the consumer stalls, so the consumer's ready never combinationally reaches the arbitration decision's state.
- Sits in front of shared dataless resources, e.g. control-merge points and a shared unit's issue port.

Parameters:
- NUM_INPUTS, 4, number of requesting channels (>=1).
- INDEX_WIDTH, 2, width of index output; must satisfy 2^INDEX_WIDTH >= NUM_INPUTS (elaboration error otherwise; width 1 used when NUM_INPUTS=1).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ins_valid  input  NUM_INPUTS  per-requester valid.
- ins_ready  output  NUM_INPUTS  per-requester ready; at most one bit high per cycle.
- outs_valid  output  1  output token available.
- outs_ready  input  1  consumer ready.
- index  output  INDEX_WIDTH  winning input of the token on the output; meaningful only when outs_valid=1.

Behaviour:
- State:
  - fullReg: 1 bit, buffer occupied.
  - idxReg: INDEX_WIDTH bits, buffered index.
  - ptr: INDEX_WIDTH bits, highest-priority input.
- Reset, synchronous on rst=1 at the clock edge: fullReg=0, idxReg=0, ptr=0. Any buffered token is discarded.
- Outputs are combinational from state and inputs, so immediately after reset: ins_ready = one-hot grant, outs_valid = OR(ins_valid), index = grant.
- Arbitration, combinational:
  - any = OR(ins_valid).
  - g = first i with ins_valid[i]=1, scanning ptr, ptr+1, ..., NUM_INPUTS-1, 0, ..., ptr-1.
  - g = 0 when any=0.
- Handshake:
  - ins_ready[i] = ~fullReg & any & (i==g); all other bits 0.
  - outs_valid = fullReg | any.
  - index = fullReg ? idxReg : g.
- Input acceptance: acc = any & ~fullReg.
- Next state:
  - fullReg <= (any | fullReg) & ~outs_ready.
  - idxReg <= g when acc & ~outs_ready; otherwise it holds.
  - ptr <= (g==NUM_INPUTS-1) ? 0 : g+1 when acc; otherwise it holds.
- Latency and throughput:
  - Zero-cycle pass-through when the buffer is empty.
  - 1 token/cycle while outs_ready stays high.
  - After a stall, the buffered token drains in the first cycle with outs_ready=1. All ins_ready are 0 that cycle; new acceptance resumes the next cycle.
- Full + outs_ready=1 in the same cycle: buffered token leaves, nothing is accepted, fullReg -> 0.
- Full + outs_ready=0: everything holds, and index stays stable while the consumer stalls.
- Requester drops valid while not granted: no effect. The protocol assumes valid is held until ready.
- ptr wrap: grant to NUM_INPUTS-1 sets ptr=0.
- NUM_INPUTS=1: ptr and index are constantly 0, and the block degenerates to a single transparent buffer slot.
- No combinational path from outs_ready to ins_ready or to index.

Test Plan (NUM_INPUTS=4, INDEX_WIDTH=2):
- Reset, then ins_valid=4'b1111, outs_ready=1 for 6 cycles -> index sequence 0,1,2,3,0,1. Exactly one ins_ready bit is high each cycle, matching index; outs_valid=1 every cycle.
- ins_valid=4'b0100, outs_ready=0 in cycle 0 -> ins_ready=4'b0100, outs_valid=1, index=2. Cycle 1: ins_ready=0, index=2, fullReg=1. Raise outs_ready in cycle 3 -> token leaves with index=2, ins_ready=0 in that cycle. Cycle 4: input 2 is accepted again (ptr=3 but only input 2 valid).
- ptr=3 via a prior grant to input 2, then ins_valid=4'b1001 -> grant 3, then 0 (wrap), then 3.
- Buffer full with index=1, assert rst for one cycle with outs_ready=0 -> next cycle with ins_valid=0: outs_valid=0, ptr=0. With ins_valid=4'b1010, grant=1.
- ins_valid=0 for 5 cycles with outs_ready toggling -> outs_valid=0, ins_ready=0, state unchanged.
- Random valid/ready traffic for 10k cycles -> every accepted input token appears exactly once, in acceptance order with correct index. No input with valid held waits more than NUM_INPUTS accepted tokens.
